// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: N-channel posted-request arbiter running timed accesses on an async SRAM
module sram_port_arbiter #(
  parameter int NCH      = 3,
  parameter int AW       = 16,
  parameter int DW       = 8,
  parameter int RD_TICKS = 4,
  parameter int WR_TICKS = 4,
  parameter int RR_MODE  = 0
) (
  input  logic                    clock_50,
  input  logic                    reset,
  input  logic [NCH-1:0]          req_valid,
  input  logic [NCH-1:0]          req_write,
  input  logic [NCH*AW-1:0]       req_addr,
  input  logic [NCH*DW-1:0]       req_wdata,
  output logic [NCH-1:0]          req_ready,
  output logic [NCH-1:0]          rsp_valid,
  output logic [DW-1:0]           rsp_rdata,
  output logic [AW-1:0]           sram_addrbus,
  output logic [DW-1:0]           sram_dout,
  output logic                    sram_dout_en,
  input  logic [DW-1:0]           sram_din,
  output logic                    sram_we_n,
  output logic                    sram_oe_n,
  output logic                    busy,
  output logic [$clog2(NCH)-1:0]  grant_id
);
  localparam int IW = $clog2(NCH);
  localparam int TW = $clog2(RD_TICKS > WR_TICKS ? RD_TICKS : WR_TICKS) + 1;
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t                 state_q, state_d;
  logic [NCH-1:0]         slot_v_q, slot_v_d, slot_w_q, slot_w_d;
  logic [NCH-1:0][AW-1:0] slot_a_q, slot_a_d;
  logic [NCH-1:0][DW-1:0] slot_d_q, slot_d_d;
  logic [NCH-1:0]         rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]          rdata_q, rdata_d, dout_q, dout_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic                   dout_en_q, dout_en_d, we_n_q, we_n_d, busy_q, busy_d;
  logic [IW-1:0]          grant_q, grant_d, win, win_fix, win_hi, win_lo;
  logic                   found_hi;
  logic [TW-1:0]          cnt_q, cnt_d;
  // winner: highest occupied slot, or first occupied slot after the last grant with wrap
  always_comb begin
    win_fix  = '0;
    win_hi   = '0;
    win_lo   = '0;
    found_hi = 1'b0;
    for (int i = 0; i < NCH; i++) if (slot_v_q[i]) win_fix = IW'(i);
    for (int i = NCH - 1; i >= 0; i--) begin
      if (slot_v_q[i]) win_lo = IW'(i);
      if (slot_v_q[i] && i > int'(grant_q)) begin
        win_hi   = IW'(i);
        found_hi = 1'b1;
      end
    end
    win = (RR_MODE != 0) ? (found_hi ? win_hi : win_lo) : win_fix;
  end
  // slot capture plus the IDLE/ACCESS sequencer that times each SRAM cycle
  always_comb begin
    state_d     = state_q;
    slot_v_d    = slot_v_q;
    slot_w_d    = slot_w_q;
    slot_a_d    = slot_a_q;
    slot_d_d    = slot_d_q;
    rsp_valid_d = '0;
    rdata_d     = rdata_q;
    dout_d      = dout_q;
    addr_d      = addr_q;
    dout_en_d   = dout_en_q;
    we_n_d      = we_n_q;
    busy_d      = busy_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    for (int i = 0; i < NCH; i++) begin
      if (req_valid[i] && !slot_v_q[i]) begin
        slot_v_d[i] = 1'b1;
        slot_w_d[i] = req_write[i];
        slot_a_d[i] = req_addr[i*AW +: AW];
        slot_d_d[i] = req_wdata[i*DW +: DW];
      end
    end
    if (state_q == IDLE) begin
      if (|slot_v_q) begin
        state_d   = ACCESS;
        grant_d   = win;
        addr_d    = slot_a_q[win];
        busy_d    = 1'b1;
        dout_en_d = slot_w_q[win];
        we_n_d    = ~slot_w_q[win];
        dout_d    = slot_w_q[win] ? slot_d_q[win] : dout_q;
        cnt_d     = slot_w_q[win] ? TW'(WR_TICKS - 1) : TW'(RD_TICKS - 1);
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end else begin
      rdata_d              = slot_w_q[grant_q] ? rdata_q : sram_din;
      rsp_valid_d[grant_q] = 1'b1;
      slot_v_d[grant_q]    = 1'b0;
      we_n_d               = 1'b1;
      dout_en_d            = 1'b0;
      busy_d               = 1'b0;
      state_d              = IDLE;
    end
  end
  // state registers; reset aborts any in-flight access and empties every slot
  always_ff @(posedge clock_50) begin
    if (reset) begin
      state_q     <= IDLE;
      slot_v_q    <= '0;
      slot_w_q    <= '0;
      slot_a_q    <= '0;
      slot_d_q    <= '0;
      rsp_valid_q <= '0;
      rdata_q     <= '0;
      dout_q      <= '0;
      addr_q      <= '0;
      dout_en_q   <= 1'b0;
      we_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      grant_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      slot_v_q    <= slot_v_d;
      slot_w_q    <= slot_w_d;
      slot_a_q    <= slot_a_d;
      slot_d_q    <= slot_d_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      dout_q      <= dout_d;
      addr_q      <= addr_d;
      dout_en_q   <= dout_en_d;
      we_n_q      <= we_n_d;
      busy_q      <= busy_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
    end
  end
  assign req_ready    = ~slot_v_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rdata_q;
  assign sram_addrbus = addr_q;
  assign sram_dout    = dout_q;
  assign sram_dout_en = dout_en_q;
  assign sram_we_n    = we_n_q;
  assign sram_oe_n    = ~we_n_q;
  assign busy         = busy_q;
  assign grant_id     = grant_q;
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Parametrised N-channel SRAM access arbiter for the CoCo FDC/cartridge CPLD. It generalises the fixed CTS/SCS/SPI request flags and the tick counter into a reusable block.
- Each requestor, for example CoCo ROM reads, CoCo register accesses and the SPI bridge, gets a single-entry posted request slot.
- The arbiter grants one slot at a time and runs a timed read or write on the external async SRAM. It returns read data with a one-cycle response strobe.
- Arbitration is selectable: fixed priority or round-robin.

Parameters:
- NCH, 3, number of requestor channels (2..8).
- AW, 16, SRAM address width.
- DW, 8, SRAM data width.
- RD_TICKS, 4, clock cycles the SRAM read is held (>=2).
- WR_TICKS, 4, clock cycles sram_we_n is held low (>=2).
- RR_MODE, 0, 0 = fixed priority (highest index wins), 1 = round-robin.

Ports:
- clock_50  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NCH  per-channel request present.
- req_write  in  NCH  per-channel: 1 = write, 0 = read.
- req_addr  in  NCH*AW  packed addresses; channel i uses bits [i*AW +: AW].
- req_wdata  in  NCH*DW  packed write data.
- req_ready  out  NCH  slot empty; the request is accepted on valid&ready.
- rsp_valid  out  NCH  one-cycle pulse when channel i's access completes (reads and writes).
- rsp_rdata  out  DW  read data; valid while any rsp_valid bit is high, held until the next read completes.
- sram_addrbus  out  AW  SRAM address.
- sram_dout  out  DW  data driven to SRAM.
- sram_dout_en  out  1  tristate enable for sram_dout; high only during writes.
- sram_din  in  DW  data from SRAM.
- sram_we_n  out  1  SRAM write enable, active low.
- sram_oe_n  out  1  SRAM output enable, active low; equals ~sram_we_n.
- busy  out  1  high while an access is in progress.
- grant_id  out  clog2(NCH)  index of the current or last granted channel.

Behaviour:
- Reset (synchronous, wins over everything):
  - All slots empty; req_ready all 1; rsp_valid 0; rsp_rdata 0.
  - sram_addrbus 0; sram_dout 0; sram_dout_en 0; sram_we_n 1; busy 0; grant_id 0; RR pointer 0.
  - Reset asserted mid-access aborts the access with no rsp_valid; sram_we_n is 1 on the next cycle.
- Slots:
  - On edge with req_valid[i] & req_ready[i], slot i latches write, addr and wdata. req_ready[i] goes low from the next cycle.
  - Requestors may drop their inputs after acceptance.
- States: IDLE, ACCESS.
- IDLE, any slot occupied:
  - Choose winner k. Fixed mode: highest occupied index. RR mode: first occupied index after the last granted index, wrapping from NCH-1 to 0.
  - Drive sram_addrbus = addr[k] and set grant_id = k; busy <= 1.
  - Write: sram_dout = wdata[k], sram_dout_en <= 1, sram_we_n <= 0, counter <= WR_TICKS-1.
  - Read: sram_dout_en <= 0, sram_we_n <= 1, counter <= RD_TICKS-1.
  - Go to ACCESS.
- IDLE, no slot occupied: stay in IDLE; outputs hold.
- ACCESS, counter != 0: decrement the counter.
- ACCESS, counter == 0:
  - Read: rsp_rdata <= sram_din.
  - Both: rsp_valid[k] <= 1 for one cycle; slot k freed (req_ready[k] = 1 next cycle); sram_we_n <= 1; sram_dout_en <= 0; busy <= 0; return to IDLE.
  - sram_addrbus holds its value until the next grant, so the address stays stable after write-enable rises.
- Latency:
  - Request accepted at edge N, all slots idle: grant at edge N+1.
  - rsp_valid high in the cycle after edge N+1+TICKS.
  - Back-to-back grants are separated by one IDLE cycle, so one access period is TICKS+1 cycles.
- Boundaries:
  - A request arriving on a channel whose slot is full is not accepted; the requestor must hold it.
  - Simultaneous new requests on several channels: all are latched in the same cycle; grant order follows the mode.
  - A channel can re-request in the same cycle its ready returns, and then competes in the following arbitration.
  - Fixed mode may starve low-index channels; this is accepted behaviour.
  - In RR mode every occupied channel is granted within NCH grants.
  - A new request arriving during ACCESS never alters the in-flight access.

Test Plan:
1. Reset high 2 cycles, then low. Ch0 read addr 0x8123 with sram_din modelled as 0x5A. Required: sram_addrbus = 0x8123 one cycle after accept; rsp_valid[0] after 1+4 further cycles; rsp_rdata = 0x5A; sram_we_n stays 1.
2. Ch2 write 0x0011 data 0xA5. Required: sram_we_n low exactly 4 cycles; sram_dout_en high for the same 4 cycles; sram_dout = 0xA5; rsp_valid[2] pulses once; sram_oe_n = ~sram_we_n throughout.
3. Fixed mode: ch0, ch1 and ch2 requests accepted on the same edge. Required: grant order 2, 1, 0; grants spaced 5 cycles apart; three rsp_valid pulses in that order.
4. RR_MODE=1: all three channels re-request continuously. Required: grant_id sequence 1, 2, 0, 1, 2, 0 starting from the reset pointer of 0; no channel is skipped.
5. Ch1 requests again while its slot is full. Required: req_ready[1] = 0 and the second request is not latched until rsp_valid[1] fires.
6. Reset asserted mid-write, two cycles into ACCESS. Required: sram_we_n = 1 on the next cycle; no rsp_valid; all req_ready = 1; busy = 0.
